uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, RX FIFO entries; power of two, range 4..256.
REQ-002 SHALL have parameter RESET_DIV, default 16'd433, divisor applied at reset.
REQ-003 SHALL have port clock  in  1  rising-edge clock.
REQ-004 SHALL have port resetn  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port cfg_div_i  in  16  new divisor value.
REQ-006 SHALL have port cfg_wr_i  in  1  one-cycle strobe that writes cfg_div_i.
REQ-007 SHALL have port cfg_thresh_i  in  $clog2(DEPTH)+1  FIFO level that raises the IRQ.
REQ-008 SHALL have port cfg_pending_o  out  1  a divisor write is waiting to be applied.
REQ-009 SHALL have port bauddiv_o  out  16  to receiver; equals active_div_q+1.
REQ-010 SHALL have port rx_byte_i  in  8  byte from the receiver.
REQ-011 SHALL have port rx_valid_i  in  1  one-cycle byte-complete pulse.
REQ-012 SHALL have port rx_busy_i  in  1  receiver is mid-frame.
REQ-013 SHALL have port rd_en_i  in  1  pop strobe.
REQ-014 SHALL have port rd_data_o  out  8  FIFO head, first-word fall-through.
REQ-015 SHALL have port rd_valid_o  out  1  FIFO not empty.
REQ-016 SHALL have port level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port overrun_o  out  1  sticky flag: a byte was dropped.
REQ-018 SHALL have port clr_overrun_i  in  1  clears overrun_o.
REQ-019 SHALL have port irq_o  out  1  level-sensitive interrupt.

Function
REQ-020 SHALL push rx_byte_i on rx_valid_i when the FIFO is not full; level_o updates the next cycle.
REQ-021 SHALL pop on rd_en_i when rd_valid_o is high; rd_en_i on an empty FIFO is ignored with no side effects.
REQ-022 SHALL, on simultaneous push and pop, perform both and leave the level unchanged; this includes the full case, which is not an overrun.
REQ-023 SHALL, on push while full with no pop, drop the byte and set overrun_o the next cycle; FIFO contents are unchanged.
REQ-024 SHALL give set priority over clr_overrun_i when both occur in the same cycle.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; level_o ranges 0..DEPTH.
REQ-026 SHALL run a divisor FSM with states IDLE and PEND.
  - IDLE + cfg_wr_i: capture pend_q and go to PEND.
  - PEND + cfg_wr_i: overwrite pend_q.
  - PEND + !rx_busy_i + !cfg_wr_i: active_div_q <= pend_q, go to IDLE.
REQ-027 SHALL never change bauddiv_o while rx_busy_i is high; cfg_pending_o = (state==PEND).
REQ-028 SHALL compute bauddiv_o as a 16-bit add of 1 to active_div_q; 16'hFFFF wraps to 0 and is documented as illegal.
REQ-029 SHALL drive irq_o = (level_o >= cfg_thresh_i && cfg_thresh_i != 0) | overrun_o | timeout term (REQ-036).

Reset
REQ-030 SHALL, while resetn is low:
  - empty the FIFO; level_o=0, rd_valid_o=0.
  - clear overrun_o and irq_o.
  - set the FSM to IDLE and cfg_pending_o=0.
  - set active_div_q=RESET_DIV.
REQ-031 SHALL, on reset in PEND, discard the pending divisor.
REQ-032 SHALL hold rd_data_o don't-care while the FIFO is empty.

Configuration
REQ-033 SHALL compile the idle-timeout feature only when macro UART_RX_TIMEOUT_EN is defined.
REQ-034 SHALL, with the macro defined, count baud periods of active_div_q+1 cycles.
  - Count only while rd_valid_o && !rx_busy_i.
  - Restart the count on push, pop, or rx_busy_i.
REQ-035 SHALL set sticky timeout_q after TIMEOUT_BITS periods; clear it on pop or when the FIFO is empty.
REQ-036 SHALL OR timeout_q into irq_o when the macro is defined; without the macro, no counter exists and the term is 0.

Structure
REQ-037 SHALL take DIV_W=16, TIMEOUT_BITS=40 and the FSM state enum from shared package uart_pkg.
REQ-038 SHALL instantiate the FIFO as sub-module uart_fifo (parameter DEPTH, width 8, FWFT, full/empty/level).

Verification
REQ-039 SHALL cover: push 0x55, 0xAA -> rd_data_o=0x55, level_o=2; pop -> rd_data_o=0xAA.
REQ-040 SHALL cover: 17 pushes, DEPTH=16, no pops -> level_o=16, overrun_o=1, 17th byte absent.
REQ-041 SHALL cover: full, push+pop same cycle -> level_o stays 16, overrun_o stays 0.
REQ-042 SHALL cover: cfg_wr_i div=100 while rx_busy_i=1 -> bauddiv_o=434 until busy falls, then 101 the next cycle.
REQ-043 SHALL cover: cfg_thresh_i=4, four pushes -> irq_o=1; one pop -> irq_o=0.
REQ-044 SHALL cover, with UART_RX_TIMEOUT_EN and div=9: one byte, idle 400 cycles -> irq_o=1; pop -> irq_o=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RX controller slice.
// Divisor width, idle-timeout length and divisor FSM states.
package uart_pkg;

  localparam int DIV_W        = 16;
  localparam int TIMEOUT_BITS = 40;

  typedef enum logic {
    IDLE,
    PEND
  } div_state_t;

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through byte FIFO with full/empty/level.
// Ports: push_i/wr_data_i in, pop_i/rd_data_o out, full_o, empty_o, level_o.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)
        level_q <= level_q + 1'b1;
      else if (pop_i && !push_i)
        level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: byte FIFO, overrun flag, safe divisor update, IRQ.
// Optional idle timeout when UART_RX_TIMEOUT_EN is defined.
// Ports: cfg_* divisor/threshold config, rx_* receiver side,
// rd_* FIFO read side, level_o, overrun_o, irq_o, bauddiv_o.
// bauddiv_o = active divisor + 1; a divisor of 16'hFFFF wraps and is illegal.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] RESET_DIV = 16'd433
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [15:0]            cfg_div_i,
  input  logic                   cfg_wr_i,
  input  logic [$clog2(DEPTH):0] cfg_thresh_i,
  output logic                   cfg_pending_o,
  output logic [15:0]            bauddiv_o,
  input  logic [7:0]             rx_byte_i,
  input  logic                   rx_valid_i,
  input  logic                   rx_busy_i,
  input  logic                   rd_en_i,
  output logic [7:0]             rd_data_o,
  output logic                   rd_valid_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overrun_o,
  input  logic                   clr_overrun_i,
  output logic                   irq_o
);

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  // A push into a full FIFO is fine when a pop frees a slot that cycle.
  assign pop  = rd_en_i && !empty;
  assign push = rx_valid_i && (!full || pop);
  assign drop = rx_valid_i && full && !pop;

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push_i    (push),
    .wr_data_i (rx_byte_i),
    .pop_i     (pop),
    .rd_data_o (rd_data_o),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level_o)
  );

  assign rd_valid_o = !empty;

  logic overrun_q;

  always_ff @(posedge clock) begin
    if (!resetn)
      overrun_q <= 1'b0;
    else if (drop)
      overrun_q <= 1'b1;
    else if (clr_overrun_i)
      overrun_q <= 1'b0;
  end

  assign overrun_o = overrun_q;

  div_state_t       state_q, state_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic [DIV_W-1:0] active_div_q, active_div_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      active_div_q <= RESET_DIV;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      active_div_q <= active_div_d;
    end
  end

  // The divisor only moves between frames, never mid-frame.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    active_div_d = active_div_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_wr_i) begin
          pend_d  = cfg_div_i;
          state_d = PEND;
        end
      end
      PEND: begin
        if (cfg_wr_i) begin
          pend_d = cfg_div_i;
        end else if (!rx_busy_i) begin
          active_div_d = pend_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_pending_o = (state_q == PEND);
  assign bauddiv_o     = active_div_q + 16'd1;

  logic tmo;

`ifdef UART_RX_TIMEOUT_EN
  localparam int BW = $clog2(TIMEOUT_BITS + 1);

  logic [DIV_W-1:0] cyc_q;
  logic [BW-1:0]    bits_q;
  logic             timeout_q;

  // Counts whole baud periods of idle line with data waiting.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cyc_q     <= '0;
      bits_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (push || pop || rx_busy_i || empty) begin
        cyc_q  <= '0;
        bits_q <= '0;
      end else if (!timeout_q) begin
        if (cyc_q == active_div_q) begin
          cyc_q  <= '0;
          bits_q <= bits_q + 1'b1;
          if (bits_q == BW'(TIMEOUT_BITS - 1))
            timeout_q <= 1'b1;
        end else begin
          cyc_q <= cyc_q + 1'b1;
        end
      end
      if (pop || empty)
        timeout_q <= 1'b0;
    end
  end

  assign tmo = timeout_q;
`else
  assign tmo = 1'b0;
`endif

  assign irq_o = ((level_o >= cfg_thresh_i) && (cfg_thresh_i != '0))
               | overrun_q
               | tmo;

endmodule
